// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the sequenced multiply-accumulate controller:
// the state encodings and the accumulator width derivation.
package mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Full signed product plus log2(DEPTH) guard bits, so a DEPTH-term sum never wraps.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned depth);
        return 2 * width + $clog2(depth);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Control, operand and status signals between a sequencer master and mac_seq_ctrl.
interface mac_seq_ctrl_if
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ACC_W = acc_width(WIDTH, DEPTH);

    logic             adv;
    logic             reuse;
    logic [WIDTH-1:0] data_in;
    logic [2:0]       state_o;
    logic [AW-1:0]    idx_o;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] acc_o;

    modport master (
        output adv, reuse, data_in,
        input  state_o, idx_o, busy, done, acc_o
    );

    modport slave (
        input  adv, reuse, data_in,
        output state_o, idx_o, busy, done, acc_o
    );
endinterface

// File: rtl/mac_seq_ctrl_mac_pipe.sv
// Two-stage signed multiply-accumulate: registered product, then accumulate
// into a sign-extended accumulator one cycle later.
module mac_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 35
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] op_a,
    input  logic signed [WIDTH-1:0] op_b,
    output logic signed [ACC_W-1:0] acc_o
);
    localparam int unsigned PW = 2 * WIDTH;

    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    vld_q, vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    // vld_q marks a product that still has to be folded into the accumulator.
    always_comb begin
        prod_d = prod_q;
        vld_d  = 1'b0;
        acc_d  = acc_q;
        if (clr) begin
            prod_d = '0;
            acc_d  = '0;
        end else begin
            if (vld_q) begin
                acc_d = acc_q + {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
            end
            if (en) begin
                prod_d = PW'(op_a) * PW'(op_b);
            end
            vld_d = en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/mac_seq_ctrl.sv
// Loads two DEPTH-entry operand banks under adv pulses, then computes their
// signed dot product through mac_pipe and reports completion.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ACC_W = acc_width(WIDTH, DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wr_a, wr_b, mac_clr, mac_en;

    logic [WIDTH-1:0] a_q [DEPTH];
    logic [WIDTH-1:0] a_d [DEPTH];
    logic [WIDTH-1:0] b_q [DEPTH];
    logic [WIDTH-1:0] b_d [DEPTH];
    logic [ACC_W-1:0] acc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.adv) begin
                    state_d = ST_LOAD_A;
                    idx_d   = '0;
                end
            end
            ST_LOAD_A: begin
                if (bus.adv) begin
                    wr_a = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = ST_LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (bus.adv) begin
                    wr_b = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = ST_COMPUTE;
                        idx_d   = '0;
                        mac_clr = 1'b1;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                mac_en = 1'b1;
                if (idx_q == LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            // Two cycles: one for the last product, one for its accumulate.
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.adv) begin
                    idx_d = '0;
                    if (bus.reuse) begin
                        state_d = ST_COMPUTE;
                        mac_clr = 1'b1;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand banks keep their contents across reset.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_a) a_d[idx_q] = bus.data_in;
        if (wr_b) b_d[idx_q] = bus.data_in;
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    mac_pipe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac_pipe (
        .clk   (clk),
        .rst   (rst),
        .clr   (mac_clr),
        .en    (mac_en),
        .op_a  (a_q[idx_q]),
        .op_b  (b_q[idx_q]),
        .acc_o (acc)
    );

    assign bus.state_o = state_q;
    assign bus.idx_o   = idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.acc_o   = acc;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed and randomized bench for mac_seq_ctrl against a dot-product reference.
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACC_W = acc_width(WIDTH, DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    mac_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    byte ma [DEPTH];
    byte mb [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dot();
        int s = 0;
        for (int i = 0; i < int'(DEPTH); i++) s += int'(ma[i]) * int'(mb[i]);
        return s;
    endfunction

    function automatic logic [31:0] exp_acc(input int v);
        logic [ACC_W-1:0] e;
        e = ACC_W'(v);
        return 32'(e);
    endfunction

    task automatic pulse(input logic [7:0] d, input logic r);
        bus.adv     = 1'b1;
        bus.data_in = d;
        bus.reuse   = r;
        tick();
        bus.adv   = 1'b0;
        bus.reuse = 1'b0;
    endtask

    // Caller has already entered LOAD_A; optional idle gaps between writes.
    task automatic load_banks(input bit gaps);
        chk("enter_load_a", 32'(bus.state_o), 32'(ST_LOAD_A));
        chk("enter_idx", 32'(bus.idx_o), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) tick();
                chk("idx_hold_a", 32'(bus.idx_o), 32'(i));
            end
            pulse(ma[i], 1'b0);
            if (i < int'(DEPTH) - 1) chk("idx_a", 32'(bus.idx_o), 32'(i + 1));
        end
        chk("enter_load_b", 32'(bus.state_o), 32'(ST_LOAD_B));
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            pulse(mb[i], 1'b0);
        end
        chk("enter_compute", 32'(bus.state_o), 32'(ST_COMPUTE));
        chk("compute_idx0", 32'(bus.idx_o), 32'd0);
        chk("acc_cleared", 32'(bus.acc_o), 32'd0);
    endtask

    // Starts in the first COMPUTE cycle; optionally pokes adv with junk data.
    task automatic run(input bit poke);
        int cyc = 0;
        int nb  = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) nb++;
            if (cyc < int'(DEPTH)) begin
                chk("state_compute", 32'(bus.state_o), 32'(ST_COMPUTE));
                chk("idx_compute", 32'(bus.idx_o), 32'(cyc));
            end else if (cyc < int'(DEPTH) + 2) begin
                chk("state_drain", 32'(bus.state_o), 32'(ST_DRAIN));
                chk("idx_drain", 32'(bus.idx_o), 32'(DEPTH - 1));
            end
            if (poke && cyc[0] == 1'b0) begin
                bus.adv     = 1'b1;
                bus.data_in = 8'($urandom);
            end
            tick();
            bus.adv = 1'b0;
            cyc++;
        end
        chk("done_latency", 32'(cyc), 32'(DEPTH + 2));
        chk("busy_cycles", 32'(nb), 32'(DEPTH + 2));
        chk("state_done", 32'(bus.state_o), 32'(ST_DONE));
        chk("idx_done", 32'(bus.idx_o), 32'd0);
        chk("acc_model", 32'(bus.acc_o), exp_acc(dot()));
    endtask

    task automatic set_seq();
        for (int i = 0; i < int'(DEPTH); i++) begin
            ma[i] = byte'(i + 1);
            mb[i] = byte'(i + 5);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.adv = 1'b0;
        bus.reuse = 1'b0;
        bus.data_in = '0;
        repeat (2) tick();
        chk("rst_state", 32'(bus.state_o), 32'(ST_IDLE));
        chk("rst_idx", 32'(bus.idx_o), 32'd0);
        chk("rst_acc", 32'(bus.acc_o), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // rst wins over adv in IDLE; IDLE holds without adv
        bus.adv = 1'b1;
        tick();
        bus.adv = 1'b0;
        chk("rst_adv_idle", 32'(bus.state_o), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(bus.state_o), 32'(ST_IDLE));

        // basic dot product
        set_seq();
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        run(1'b0);
        chk("basic_acc70", 32'(bus.acc_o), 32'd70);
        tick();
        chk("done_holds_acc", 32'(bus.acc_o), 32'd70);

        // signed operands, entered from DONE with reuse=0
        for (int i = 0; i < int'(DEPTH); i++) begin ma[i] = 8'shFF; mb[i] = 8'sh7F; end
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        run(1'b0);
        chk("signed_acc", 32'(bus.acc_o), 32'h3FE04);

        // worst case magnitude, then reuse
        for (int i = 0; i < int'(DEPTH); i++) begin ma[i] = 8'sh80; mb[i] = 8'sh80; end
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        run(1'b0);
        chk("worst_acc", 32'(bus.acc_o), 32'd65536);
        pulse(8'h00, 1'b1);
        chk("reuse_state", 32'(bus.state_o), 32'(ST_COMPUTE));
        chk("reuse_clear", 32'(bus.acc_o), 32'd0);
        run(1'b0);
        chk("reuse_acc", 32'(bus.acc_o), 32'd65536);

        // adv ignored during COMPUTE/DRAIN; banks intact on reuse
        set_seq();
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        run(1'b1);
        chk("poke_acc70", 32'(bus.acc_o), 32'd70);
        pulse(8'h00, 1'b1);
        run(1'b0);
        chk("poke_banks_kept", 32'(bus.acc_o), 32'd70);

        // randomized operands and adv spacing
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ma[i] = byte'($urandom);
                mb[i] = byte'($urandom);
            end
            pulse(8'h00, 1'b0);
            load_banks(1'b1);
            run(n[0]);
        end

        // reset in the second COMPUTE cycle
        set_seq();
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", 32'(bus.state_o), 32'(ST_IDLE));
        chk("midrst_acc", 32'(bus.acc_o), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_idx", 32'(bus.idx_o), 32'd0);
        pulse(8'h00, 1'b0);
        load_banks(1'b0);
        run(1'b0);
        chk("after_rst_acc70", 32'(bus.acc_o), 32'd70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, signed two's complement.
REQ-002 Parameter DEPTH, default 8: entries per operand bank; power of two, >= 2.
REQ-003 Derived constants: AW = clog2(DEPTH); ACC_W = 2*WIDTH + AW.
REQ-004 Ports (one clock; reset is synchronous and active-high):
- clk  in  1: sole clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- adv  in  1: single-cycle advance pulse, already debounced and synchronised.
- reuse  in  1: sampled only with adv in DONE; 1 = recompute with stored operands.
- data_in  in  WIDTH: operand value written on adv during load states.
- state_o  out  3: current FSM state encoding.
- idx_o  out  AW: current load or compute index.
- busy  out  1: high in COMPUTE and DRAIN.
- done  out  1: high in DONE.
- acc_o  out  ACC_W: signed accumulator.

Function
REQ-005 States, in fixed encoding: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, DRAIN=4, DONE=5. Encodings 6 and 7 return to IDLE on the next cycle.
REQ-006 IDLE: adv moves to LOAD_A with idx=0; otherwise the block holds.
REQ-007 LOAD_A: adv writes data_in to A[idx] and increments idx. When adv arrives at idx=DEPTH-1, the write occurs, the FSM moves to LOAD_B and idx becomes 0.
REQ-008 LOAD_B: same rule as LOAD_A, writing B. adv at idx=DEPTH-1 writes, moves to COMPUTE, sets idx=0 and clears acc_o to 0 in the same edge.
REQ-009 COMPUTE lasts exactly DEPTH cycles. In each cycle A[idx]*B[idx] (full 2*WIDTH signed product) is registered and idx increments. After idx=DEPTH-1, the FSM moves to DRAIN.
REQ-010 The registered product is sign-extended to ACC_W and added to acc_o one cycle later. The multiply-accumulate is a 2-stage pipeline with no overflow, because ACC_W covers the worst case.
REQ-011 DRAIN lasts exactly 2 cycles, then the FSM moves to DONE. done rises exactly DEPTH+2 cycles after the first COMPUTE cycle, and acc_o is final in that same cycle.
REQ-012 adv is ignored in COMPUTE and DRAIN; no write occurs and the state does not change.
REQ-013 DONE: acc_o holds its value.
- adv with reuse=1: moves to COMPUTE, clears acc_o, sets idx=0, and keeps both banks.
- adv with reuse=0: moves to LOAD_A with idx=0; bank contents are retained until overwritten.
REQ-014 In IDLE and DONE, idx_o = 0. In the load states it shows the next write index. In COMPUTE it shows the index being issued. In DRAIN it holds DEPTH-1.
REQ-015 busy and done are decoded directly from the state register, with no extra latency.
REQ-016 The operand banks have no read-before-write hazard: all writes complete before COMPUTE begins.

Reset
REQ-017 rst high at a rising edge forces the following, regardless of state (including mid-COMPUTE or mid-DRAIN):
- state = IDLE
- idx = 0
- acc_o = 0
- pipeline product register = 0
- busy = 0, done = 0
REQ-018 Bank contents are not cleared by rst. The values they hold after reset are unspecified until they are reloaded.
REQ-019 rst takes priority over a simultaneous adv.

Structure
REQ-020 A shared package holds the state enumeration/encodings and the ACC_W derivation function; the controller and the bench import it.
REQ-021 One sub-module, mac_pipe (registered multiply plus accumulate, with clear and enable inputs), is instantiated once. The FSM, the banks and the index counter stay in mac_seq_ctrl.
REQ-022 Both operand banks are register arrays local to mac_seq_ctrl. No tri-state buses are used.

Verification (WIDTH=8, DEPTH=4, ACC_W=18)
REQ-023 Basic dot product: load A=1,2,3,4 and B=5,6,7,8.
- Required: acc_o=70.
- Required: done asserted exactly 6 cycles after the first COMPUTE cycle.
- Required: busy high for exactly 6 cycles.
REQ-024 Signed operands: A=8'hFF (x4), B=8'h7F (x4). Required: acc_o = -508 (18'h3FE04).
REQ-025 Worst case: A=B=8'h80 (x4). Required: acc_o=65536 with no wrap. Then adv with reuse=1: required acc_o returns to 65536 after a new 6-cycle busy window.
REQ-026 adv pulses during COMPUTE and DRAIN. Required: no state change, the result is still 70, and the bank contents are unchanged.
REQ-027 rst asserted at COMPUTE cycle 2, then released. Required, on the next cycle:
- state_o=0, acc_o=0, done=0, busy=0.
- A subsequent full reload of the REQ-023 values yields 70.
REQ-028 rst and adv high together in IDLE. Required: the block remains in IDLE. From DONE, adv with reuse=0 enters LOAD_A with idx_o=0.
